// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/pause/lap sequencer for a 0..MAX_COUNT centisecond counter.
// Define STOPWATCH_DEBOUNCE_EN to insert a counter-based debouncer after each button synchronizer.
module stopwatch_ctrl #(
    parameter int CLK_HZ      = 125_000_000,
    parameter int TICK_HZ     = 100,
    parameter int DEBOUNCE_MS = 10,
    parameter int MAX_COUNT   = 9999
) (
    input  logic        sysclk,
    input  logic        i_rst_n,
    input  logic        i_btn_ss,
    input  logic        i_btn_lap,
    input  logic        i_btn_clr,
    output logic [13:0] o_count,
    output logic        o_running,
    output logic [1:0]  o_state,
    output logic        o_wrap,
    output logic [7:0]  o_led
);
    localparam int TICK_CYC = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // Button vectors are ordered {clr, ss, lap}.
    logic [2:0] sync_p0, sync_p1, lvl, lvl_d, press;

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {i_btn_clr, i_btn_ss, i_btn_lap};
            sync_p1 <= sync_p0;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DEB_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DEB_CYC = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int DEB_W   = $clog2(DEB_CYC + 1);

    logic [DEB_W-1:0] deb_cnt [3];
    logic [2:0]       deb_lvl;

    // The filtered level follows only after DEB_CYC consecutive differing samples.
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
            deb_lvl <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                    deb_lvl[i] <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = deb_lvl;
`else
    // DEBOUNCE_MS only matters when the debouncer is built.
    localparam int unused_debounce_ms = DEBOUNCE_MS;

    assign lvl = sync_p1;
`endif

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl_d <= '0;
            press <= '0;
        end else begin
            lvl_d <= lvl;
            press <= lvl & ~lvl_d;
        end
    end

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [13:0]       live_cnt, live_nxt, lap_val;
    logic [3:0]        lap_cnt;
    logic              wrap, counting, tick;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (tick_cnt == TICK_W'(TICK_CYC - 1));

    always_comb begin
        live_nxt = live_cnt;
        if (tick) live_nxt = (live_cnt == 14'(MAX_COUNT)) ? 14'd0 : live_cnt + 14'd1;
    end

    // Ticks use the pre-transition state; a lap captures the post-tick value.
    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            live_cnt <= '0;
            lap_val  <= '0;
            lap_cnt  <= '0;
            wrap     <= 1'b0;
        end else if (press[2]) begin
            state    <= IDLE;
            tick_cnt <= '0;
            live_cnt <= '0;
            lap_val  <= '0;
            lap_cnt  <= '0;
            wrap     <= 1'b0;
        end else begin
            if (counting) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            live_cnt <= live_nxt;
            wrap     <= tick && (live_cnt == 14'(MAX_COUNT));
            if (press[1]) begin
                state <= (state == IDLE || state == PAUSE) ? RUN : PAUSE;
            end else if (press[0]) begin
                if (state == RUN) begin
                    state   <= LAP;
                    lap_val <= live_nxt;
                    if (lap_cnt != 4'd8) lap_cnt <= lap_cnt + 4'd1;
                end else if (state == LAP) begin
                    state <= RUN;
                end
            end
        end
    end

    assign o_state   = state;
    assign o_running = counting;
    assign o_wrap    = wrap;
    assign o_count   = (state == LAP) ? lap_val : live_cnt;

    always_comb begin
        o_led = '0;
        for (int i = 0; i < 8; i++) o_led[i] = (lap_cnt > 4'(i));
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized and directed bench for stopwatch_ctrl with a time-accumulation reference model.
module tb_stopwatch_ctrl;
    localparam int CLK_HZ      = 1000;
    localparam int TICK_HZ     = 100;
    localparam int DEBOUNCE_MS = 2;
    localparam int MAX_COUNT   = 12;
    localparam int TICK_CYC    = CLK_HZ / TICK_HZ;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DEB_CYC     = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LAT         = 3 + DEB_CYC;
    localparam logic [1:0] GLITCH_STATE = 2'b00;
`else
    localparam int LAT         = 3;
    localparam logic [1:0] GLITCH_STATE = 2'b01;
`endif

    logic        sysclk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_btn_ss = 1'b0, i_btn_lap = 1'b0, i_btn_clr = 1'b0;
    logic [13:0] o_count;
    logic        o_running;
    logic [1:0]  o_state;
    logic        o_wrap;
    logic [7:0]  o_led;
    logic [25:0] obs;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .MAX_COUNT(MAX_COUNT)
    ) dut (
        .sysclk(sysclk), .i_rst_n(i_rst_n),
        .i_btn_ss(i_btn_ss), .i_btn_lap(i_btn_lap), .i_btn_clr(i_btn_clr),
        .o_count(o_count), .o_running(o_running), .o_state(o_state),
        .o_wrap(o_wrap), .o_led(o_led)
    );

    always #5 sysclk = ~sysclk;
    assign obs = {o_state, o_running, o_count, o_wrap, o_led};

    // Reference model: count = accumulated run time / TICK_CYC, modulo MAX_COUNT+1.
    int  m_state, m_run, m_lap_val, m_lap_cnt, edge_n;
    bit  m_wrap, prv_ss, prv_lap, prv_clr;
    int  q_ss[$], q_lap[$], q_clr[$];

    always @(posedge sysclk or negedge i_rst_n) begin : model
        bit a_ss, a_lap, a_clr, run_now;
        int en, run_n, live, st, lv, lc;
        bit wr;
        if (!i_rst_n) begin
            m_state <= 0; m_run <= 0; m_lap_val <= 0; m_lap_cnt <= 0; m_wrap <= 0;
            edge_n <= 0; prv_ss <= 0; prv_lap <= 0; prv_clr <= 0;
            q_ss.delete(); q_lap.delete(); q_clr.delete();
        end else begin
            en = edge_n + 1;
            a_ss  = (q_ss.size()  > 0) && (q_ss[0]  == en);
            a_lap = (q_lap.size() > 0) && (q_lap[0] == en);
            a_clr = (q_clr.size() > 0) && (q_clr[0] == en);
            if (a_ss)  void'(q_ss.pop_front());
            if (a_lap) void'(q_lap.pop_front());
            if (a_clr) void'(q_clr.pop_front());
            if (i_btn_ss  && !prv_ss)  q_ss.push_back(en + LAT);
            if (i_btn_lap && !prv_lap) q_lap.push_back(en + LAT);
            if (i_btn_clr && !prv_clr) q_clr.push_back(en + LAT);

            run_now = (m_state == 1) || (m_state == 3);
            run_n = m_run + (run_now ? 1 : 0);
            live  = (run_n / TICK_CYC) % (MAX_COUNT + 1);
            wr    = run_now && (run_n % TICK_CYC == 0) && (live == 0);
            st = m_state; lv = m_lap_val; lc = m_lap_cnt;
            if (a_clr) begin
                st = 0; run_n = 0; lv = 0; lc = 0; wr = 0;
            end else if (a_ss) begin
                st = run_now ? 2 : 1;
            end else if (a_lap) begin
                if (m_state == 1) begin
                    st = 3; lv = live; lc = (lc < 8) ? lc + 1 : 8;
                end else if (m_state == 3) begin
                    st = 1;
                end
            end
            m_state <= st; m_run <= run_n; m_lap_val <= lv; m_lap_cnt <= lc; m_wrap <= wr;
            edge_n <= en;
            prv_ss <= i_btn_ss; prv_lap <= i_btn_lap; prv_clr <= i_btn_clr;
        end
    end

    function automatic logic [25:0] exp_vec();
        logic [13:0] cnt;
        logic [7:0]  led;
        cnt = (m_state == 3) ? 14'(m_lap_val) : 14'((m_run / TICK_CYC) % (MAX_COUNT + 1));
        for (int i = 0; i < 8; i++) led[i] = (m_lap_cnt > i);
        return {2'(m_state), (m_state == 1 || m_state == 3), cnt, m_wrap, led};
    endfunction

    task automatic press(input bit ss, input bit lap, input bit clr);
        @(negedge sysclk);
        i_btn_ss = ss; i_btn_lap = lap; i_btn_clr = clr;
        repeat (5) @(negedge sysclk);
        i_btn_ss = 0; i_btn_lap = 0; i_btn_clr = 0;
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        repeat (3) @(negedge sysclk);
        checks++;
        if (obs !== 26'd0) begin
            errors++; $display("FAIL reset_values got=%h exp=%h", obs, 26'd0);
        end
        i_rst_n = 1;
        repeat (3) @(negedge sysclk);
        checks++;
        if (obs !== 26'd0) begin
            errors++; $display("FAIL idle_after_reset got=%h exp=%h", obs, 26'd0);
        end
    endtask

    task automatic test_run();
        int n = 0;
        press(1, 0, 0);
        while (o_state !== 2'b01 && n < 20) begin @(negedge sysclk); n++; end
        checks++;
        if (o_state !== 2'b01) begin
            errors++; $display("FAIL run_start got=%b exp=01", o_state);
        end
        repeat (100) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL run_track t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (o_count !== 14'd10 || o_state !== 2'b01 || o_running !== 1'b1) begin
            errors++; $display("FAIL run_100 got=%0d/%b/%b exp=10/01/1", o_count, o_state, o_running);
        end
    endtask

    task automatic test_pause();
        press(1, 0, 0);
        repeat (55) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL pause_hold t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (o_state !== 2'b10 || o_running !== 1'b0) begin
            errors++; $display("FAIL pause_state got=%b/%b exp=10/0", o_state, o_running);
        end
        press(1, 0, 0);
        repeat (40) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL resume_phase t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
    endtask

    task automatic test_lap();
        int n = 0;
        press(0, 0, 1);
        repeat (8) @(negedge sysclk);
        press(1, 0, 0);
        while (o_count !== 14'd7 && n < 200) begin @(negedge sysclk); n++; end
        checks++;
        if (o_count !== 14'd7) begin
            errors++; $display("FAIL lap_reach7 got=%0d exp=7", o_count);
        end
        press(0, 1, 0);
        repeat (30) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL lap_track t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (o_state !== 2'b11 || o_count !== 14'd7 || o_led !== 8'h01 || o_running !== 1'b1) begin
            errors++; $display("FAIL lap_hold got=%b/%0d/%h exp=11/7/01", o_state, o_count, o_led);
        end
        press(0, 1, 0);
        repeat (8) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL lap_release t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (o_state !== 2'b01 || o_led !== 8'h01) begin
            errors++; $display("FAIL lap_back_run got=%b/%h exp=01/01", o_state, o_led);
        end
    endtask

    task automatic test_wrap_led();
        int n = 0;
        logic [13:0] prev = '0;
        press(0, 0, 1);
        repeat (8) @(negedge sysclk);
        press(1, 0, 0);
        while (o_wrap !== 1'b1 && n < 300) begin
            prev = o_count;
            @(negedge sysclk); n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL wrap_track t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (o_wrap !== 1'b1 || o_count !== 14'd0 || prev !== 14'(MAX_COUNT)) begin
            errors++; $display("FAIL wrap_event got=%b/%0d prev=%0d exp=1/0 prev=%0d", o_wrap, o_count, prev, MAX_COUNT);
        end
        @(negedge sysclk);
        checks++;
        if (o_wrap !== 1'b0) begin
            errors++; $display("FAIL wrap_pulse_width got=%b exp=0", o_wrap);
        end
        for (int k = 0; k < 18; k++) begin
            press(0, 1, 0);
            repeat (6) begin
                @(negedge sysclk);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL led_track t=%0t got=%h exp=%h", $time, obs, exp_vec());
                end
            end
        end
        checks++;
        if (o_led !== 8'hFF) begin
            errors++; $display("FAIL led_saturate got=%h exp=ff", o_led);
        end
    endtask

    task automatic test_clr_ss();
        press(0, 0, 1);
        repeat (8) @(negedge sysclk);
        press(1, 0, 0);
        repeat (25) @(negedge sysclk);
        press(1, 0, 1);
        repeat (4) @(negedge sysclk);
        checks++;
        if (o_state !== 2'b00 || o_count !== 14'd0 || o_led !== 8'h00 || o_running !== 1'b0) begin
            errors++; $display("FAIL clr_priority got=%b/%0d/%h exp=00/0/00", o_state, o_count, o_led);
        end
        press(1, 0, 0);
        repeat (35) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL clr_rerun t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        @(negedge sysclk);
        #2 i_rst_n = 0;
        #1;
        checks++;
        if (obs !== 26'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=%h", obs, 26'd0);
        end
        @(negedge sysclk);
        i_rst_n = 1;
        repeat (30) @(negedge sysclk);
        checks++;
        if (o_state !== 2'b00 || o_count !== 14'd0 || obs !== exp_vec()) begin
            errors++; $display("FAIL stay_idle_after_reset got=%h exp=%h", obs, 26'd0);
        end
    endtask

    task automatic test_glitch();
        @(negedge sysclk);
        i_btn_ss = 1;
        @(negedge sysclk);
        i_btn_ss = 0;
        repeat (12) @(negedge sysclk);
        checks++;
        if (o_state !== GLITCH_STATE) begin
            errors++; $display("FAIL glitch_press got=%b exp=%b", o_state, GLITCH_STATE);
        end
        press(0, 0, 1);
        repeat (8) @(negedge sysclk);
        press(1, 0, 0);
        repeat (15) begin
            @(negedge sysclk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL long_press t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (o_state !== 2'b01) begin
            errors++; $display("FAIL long_press_state got=%b exp=01", o_state);
        end
    endtask

    task automatic test_random();
        int r, gap;
        press(0, 0, 1);
        repeat (8) @(negedge sysclk);
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: press(1, 0, 0);
                5, 6, 7:       press(0, 1, 0);
                8:             press(1, 1, 0);
                default:       press(0, 0, 1);
            endcase
            gap = $urandom_range(8, 40);
            repeat (gap) begin
                @(negedge sysclk);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL random_seq it=%0d got=%h exp=%h", it, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_lap();
        test_wrap_led();
        test_clr_ss();
        test_glitch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
